// File: rtl/mor1kx_bus_if_wb_burst.sv
// Wishbone B3 master bridge for the mor1kx cache/LSU port: single and wrapping-burst
// transfers, bounded rty retry, bus watchdog; address and control outputs are registered.
module mor1kx_bus_if_wb_burst #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int BURST_LENGTH = 8,
  parameter int RETRY_LIMIT  = 4,
  parameter int RETRY_DELAY  = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_i,
  input  logic                    cpu_burst_i,
  input  logic                    cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]   cpu_adr_i,
  input  logic [DATA_WIDTH/8-1:0] cpu_bsel_i,
  input  logic [DATA_WIDTH-1:0]   cpu_dat_i,
  output logic                    cpu_ack_o,
  output logic                    cpu_err_o,
  output logic [DATA_WIDTH-1:0]   cpu_dat_o,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [2:0]              wbm_cti_o,
  output logic [1:0]              wbm_bte_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i
);
  localparam int OFF  = $clog2(DATA_WIDTH/8);
  localparam int BL_W = $clog2(BURST_LENGTH);
  localparam int RC_W = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam int DL_W = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFF) - 1);
  localparam logic [BL_W-1:0]       BEAT_LAST  = BL_W'(BURST_LENGTH - 1);
  localparam logic [BL_W-1:0]       BEAT_PEN   = BL_W'(BURST_LENGTH - 2);
  localparam logic [RC_W-1:0]       RC_MAX     = RC_W'(RETRY_LIMIT);
  localparam logic [DL_W-1:0]       DL_LAST    = DL_W'(RETRY_DELAY - 1);
  localparam logic [WD_W-1:0]       WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]            BTE        = (BURST_LENGTH == 4) ? 2'b01 :
                                                 (BURST_LENGTH == 8) ? 2'b10 : 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RETRY, S_DONE} state_t;

  state_t                r_state;
  logic                  r_cyc, r_we, r_burst, r_err_pulse;
  logic [2:0]            r_cti;
  logic [1:0]            r_bte;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [BL_W-1:0]       r_beat;
  logic [RC_W-1:0]       r_retry;
  logic [DL_W-1:0]       r_dly;
  logic [WD_W-1:0]       r_wd;

  logic w_active, w_last;

  assign w_active = (r_state == S_ACTIVE);
  assign w_last   = ~r_burst | (r_beat == BEAT_LAST);

  // err beats ack in the same cycle; rst suppresses any response to the CPU.
  assign cpu_ack_o = w_active & cpu_req_i & wbm_ack_i & ~wbm_err_i & ~rst;
  assign cpu_err_o = ((wbm_err_i & w_active) | r_err_pulse) & ~rst;
  assign cpu_dat_o = wbm_dat_i;

  assign wbm_adr_o = r_adr;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_cti_o = r_cti;
  assign wbm_bte_o = r_bte;
  assign wbm_sel_o = cpu_bsel_i;
  assign wbm_dat_o = cpu_dat_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_burst     <= 1'b0;
      r_err_pulse <= 1'b0;
      r_cti       <= 3'b000;
      r_bte       <= 2'b00;
      r_adr       <= '0;
      r_beat      <= '0;
      r_retry     <= '0;
      r_dly       <= '0;
      r_wd        <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req_i) begin
            r_state <= S_ACTIVE;
            r_cyc   <= 1'b1;
            r_adr   <= cpu_adr_i & ALIGN_MASK;
            r_we    <= cpu_we_i;
            r_burst <= cpu_burst_i;
            r_cti   <= cpu_burst_i ? 3'b010 : 3'b000;
            r_bte   <= cpu_burst_i ? BTE : 2'b00;
            r_beat  <= '0;
            r_retry <= '0;
            r_wd    <= '0;
          end else begin
            r_we  <= 1'b0;
            r_cti <= 3'b000;
            r_bte <= 2'b00;
          end
        end
        S_ACTIVE: begin
          r_wd <= r_wd + WD_W'(1);
          if (!cpu_req_i) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
          end else if (wbm_err_i) begin
            r_state <= S_DONE;
            r_cyc   <= 1'b0;
          end else if (wbm_ack_i) begin
            r_retry <= '0;
            r_wd    <= '0;
            if (w_last) begin
              r_state <= S_DONE;
              r_cyc   <= 1'b0;
            end else begin
              // Wrap inside the aligned line: only the beat-index bits advance.
              r_beat              <= r_beat + BL_W'(1);
              r_adr[OFF +: BL_W]  <= r_adr[OFF +: BL_W] + BL_W'(1);
              r_cti               <= (r_beat == BEAT_PEN) ? 3'b111 : 3'b010;
            end
          end else if (wbm_rty_i) begin
            r_wd  <= '0;
            r_cyc <= 1'b0;
            if (r_retry != RC_MAX) begin
              r_retry <= r_retry + RC_W'(1);
              r_dly   <= '0;
              r_state <= S_RETRY;
            end else begin
              r_err_pulse <= 1'b1;
              r_state     <= S_DONE;
            end
          end else if (TIMEOUT != 0 && r_wd == WD_LAST) begin
            r_err_pulse <= 1'b1;
            r_state     <= S_DONE;
            r_cyc       <= 1'b0;
          end
        end
        S_RETRY: begin
          if (!cpu_req_i) begin
            r_state <= S_IDLE;
          end else if (r_dly == DL_LAST) begin
            r_state <= S_ACTIVE;
            r_cyc   <= 1'b1;
            r_wd    <= '0;
          end else begin
            r_dly <= r_dly + DL_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mor1kx_bus_if_wb_burst.sv
// Randomized bench for mor1kx_bus_if_wb_burst: each transaction is expanded into a per-cycle
// timeline of slave responses and expected bus/CPU activity, then replayed against the bridge.
`timescale 1ns/1ps
module tb_mor1kx_bus_if_wb_burst;
  localparam int DW = 32, AW = 32, BL = 8, RL = 2, RD = 2, TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_i, cpu_burst_i, cpu_we_i;
  logic [AW-1:0] cpu_adr_i;
  logic [3:0]    cpu_bsel_i;
  logic [DW-1:0] cpu_dat_i;
  logic          cpu_ack_o, cpu_err_o;
  logic [DW-1:0] cpu_dat_o;
  logic [AW-1:0] wbm_adr_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [2:0]    wbm_cti_o;
  logic [1:0]    wbm_bte_o;
  logic [3:0]    wbm_sel_o;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [DW-1:0] wbm_dat_i;

  always #5 clk = ~clk;

  mor1kx_bus_if_wb_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LENGTH(BL),
    .RETRY_LIMIT(RL), .RETRY_DELAY(RD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_burst_i(cpu_burst_i), .cpu_we_i(cpu_we_i),
    .cpu_adr_i(cpu_adr_i), .cpu_bsel_i(cpu_bsel_i), .cpu_dat_i(cpu_dat_i),
    .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o), .cpu_dat_o(cpu_dat_o),
    .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wbm_dat_i(wbm_dat_i)
  );

  // One clock cycle of the expected timeline.
  typedef struct {
    bit          req;
    bit          cyc;
    logic [31:0] adr;
    logic [2:0]  cti;
    int          beat;
    bit          s_ack, s_err, s_rty;
    bit          e_ack, e_err;
  } slot_t;

  slot_t       plan[$];
  logic [31:0] wdata[BL];
  bit          cur_we, cur_burst;
  logic [31:0] cur_adr;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic slot_t mk(int req, int cyc, logic [31:0] adr, int cti, int beat,
                               int sa, int se, int sr, int ea, int ee);
    slot_t s;
    s.req = (req != 0);  s.cyc = (cyc != 0);  s.adr = adr;  s.cti = 3'(cti);
    s.beat = beat;
    s.s_ack = (sa != 0); s.s_err = (se != 0); s.s_rty = (sr != 0);
    s.e_ack = (ea != 0); s.e_err = (ee != 0);
    return s;
  endfunction

  // Expands one CPU transaction into the cycle-by-cycle activity the bridge must show.
  task automatic build_plan(input bit burst, input bit we, input logic [31:0] adr,
                            input int wmax, input int rty_beat, input int rty_n,
                            input int err_beat, input int abort_beat, input bit silent);
    int          nb, st, w;
    logic [31:0] al, a;
    int          cti;
    plan.delete();
    cur_burst = burst; cur_we = we; cur_adr = adr;
    foreach (wdata[i]) wdata[i] = $urandom;
    nb = burst ? BL : 1;
    al = adr - (adr % 4);
    st = int'((al % 32) / 4);
    plan.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (silent) begin
      repeat (TO) plan.push_back(mk(1, 1, al, burst ? 2 : 0, 0, 0, 0, 0, 0, 0));
      plan.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      return;
    end
    for (int k = 0; k < nb; k++) begin
      a   = burst ? (al - (al % 32) + 32'((st + k) % BL) * 4) : al;
      cti = !burst ? 0 : (k == nb - 1) ? 7 : 2;
      for (int r = 0; r < 8; r++) begin
        w = $urandom_range(0, wmax);
        repeat (w) plan.push_back(mk(1, 1, a, cti, k, 0, 0, 0, 0, 0));
        if (k == abort_beat) begin
          plan.push_back(mk(0, 1, a, cti, k, 1, 0, 0, 0, 0));
          plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          return;
        end
        if (k == rty_beat && r < rty_n) begin
          plan.push_back(mk(1, 1, a, cti, k, 0, 0, 1, 0, 0));
          if (r < RL) begin
            repeat (RD) plan.push_back(mk(1, 0, 0, 0, k, 0, 0, 0, 0, 0));
            continue;
          end
          plan.push_back(mk(1, 0, 0, 0, k, 0, 0, 0, 0, 1));
          plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          return;
        end
        if (k == err_beat) begin
          plan.push_back(mk(1, 1, a, cti, k, $urandom % 2, 1, $urandom % 2, 0, 1));
          plan.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          return;
        end
        plan.push_back(mk(1, 1, a, cti, k, 1, 0, $urandom % 2, 1, 0));
        break;
      end
    end
    plan.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic run_plan(input int upto);
    slot_t       s;
    logic [31:0] rd;
    logic [3:0]  sel;
    for (int i = 0; i < plan.size() && i < upto; i++) begin
      s = plan[i];
      @(negedge clk);
      rd  = $urandom;
      sel = 4'($urandom);
      cpu_req_i   = s.req;
      cpu_we_i    = (i == 0) ? cur_we : 1'($urandom);
      cpu_burst_i = (i == 0) ? cur_burst : 1'($urandom);
      cpu_adr_i   = (i == 0) ? cur_adr : $urandom;
      cpu_bsel_i  = sel;
      cpu_dat_i   = wdata[s.beat];
      wbm_dat_i   = rd;
      if (s.cyc) begin
        wbm_ack_i = s.s_ack; wbm_err_i = s.s_err; wbm_rty_i = s.s_rty;
      end else begin
        wbm_ack_i = 1'($urandom); wbm_err_i = 1'($urandom); wbm_rty_i = 1'($urandom);
      end
      #1;
      check_eq("cyc", 32'(wbm_cyc_o), 32'(s.cyc));
      check_eq("stb", 32'(wbm_stb_o), 32'(s.cyc));
      if (s.cyc) begin
        check_eq("adr", wbm_adr_o, s.adr);
        check_eq("cti", 32'(wbm_cti_o), 32'(s.cti));
        check_eq("we", 32'(wbm_we_o), 32'(cur_we));
        check_eq("sel", 32'(wbm_sel_o), 32'(sel));
        if (cur_burst) check_eq("bte", 32'(wbm_bte_o), 32'd2);
        if (cur_we) check_eq("wdat", wbm_dat_o, wdata[s.beat]);
      end
      check_eq("ack", 32'(cpu_ack_o), 32'(s.e_ack));
      check_eq("err", 32'(cpu_err_o), 32'(s.e_err));
      if (s.e_ack && !cur_we) check_eq("rdat", cpu_dat_o, rd);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_cyc"}, 32'(wbm_cyc_o), 32'd0);
    check_eq({tag, "_stb"}, 32'(wbm_stb_o), 32'd0);
    check_eq({tag, "_we"},  32'(wbm_we_o),  32'd0);
    check_eq({tag, "_cti"}, 32'(wbm_cti_o), 32'd0);
    check_eq({tag, "_bte"}, 32'(wbm_bte_o), 32'd0);
    check_eq({tag, "_adr"}, wbm_adr_o,      32'd0);
    check_eq({tag, "_ack"}, 32'(cpu_ack_o), 32'd0);
    check_eq({tag, "_err"}, 32'(cpu_err_o), 32'd0);
  endtask

  initial begin
    int kind, nb, rb, rn, eb, ab;
    bit b;
    rst = 1'b1;
    cpu_req_i = 1'b0; cpu_burst_i = 1'b0; cpu_we_i = 1'b0; cpu_adr_i = '0;
    cpu_bsel_i = '0; cpu_dat_i = '0;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = '0;
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset");
    rst = 1'b0;

    build_plan(0, 0, 32'h104, 0, -1, 0, -1, -1, 0); run_plan(1000);  // single read
    build_plan(1, 0, 32'h118, 0, -1, 0, -1, -1, 0); run_plan(1000);  // wrapping burst read
    build_plan(1, 1, 32'h240, 2, -1, 0, -1, -1, 0); run_plan(1000);  // burst write, wait states
    build_plan(1, 0, 32'h31C, 1, 3, 2, -1, -1, 0);  run_plan(1000);  // two rty then ack
    build_plan(1, 0, 32'h31C, 1, 3, 3, -1, -1, 0);  run_plan(1000);  // rty past the limit
    build_plan(1, 0, 32'h400, 0, -1, 0, -1, -1, 1); run_plan(1000);  // silent slave
    build_plan(1, 0, 32'h500, 0, -1, 0, 2, -1, 0);  run_plan(1000);  // err on beat 2
    build_plan(1, 1, 32'h600, 1, -1, 0, -1, 4, 0);  run_plan(1000);  // abort mid burst

    build_plan(1, 0, 32'h700, 0, -1, 0, -1, -1, 0);
    run_plan(4);
    @(negedge clk);
    rst = 1'b1; cpu_req_i = 1'b1; wbm_ack_i = 1'b1; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    @(negedge clk);
    #1 check_idle_outputs("rst_mid");
    rst = 1'b0; cpu_req_i = 1'b0; wbm_ack_i = 1'b0;

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      b    = 1'($urandom);
      nb   = b ? BL : 1;
      rb = -1; rn = 0; eb = -1; ab = -1;
      case (kind)
        1: begin rb = $urandom_range(0, nb - 1); rn = $urandom_range(1, 3); end
        2: eb = $urandom_range(0, nb - 1);
        3: ab = $urandom_range(0, nb - 1);
        default: ;
      endcase
      build_plan(b, 1'($urandom), $urandom, $urandom_range(0, 2), rb, rn, eb, ab, kind == 4);
      run_plan(1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
